// File: rtl/cdb_broadcaster_if.sv
// FU-to-CDB bundle: FU result handshake, flush, and the registered broadcast
// {cdb_valid, cdb_rob_tag, cdb_value} plus status outputs.
interface cdb_broadcaster_if #(
  parameter int NUM_FU      = 4,
  parameter int ROB_TAG_LEN = 6,
  parameter int VAL_W       = 32
);
  logic                                   flush;
  logic [NUM_FU-1:0]                      fu_valid;
  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]     fu_rob_tag;
  logic [NUM_FU-1:0][VAL_W-1:0]           fu_value;
  logic [NUM_FU-1:0]                      fu_stall;
  logic                                   cdb_valid;
  logic [ROB_TAG_LEN-1:0]                 cdb_rob_tag;
  logic [VAL_W-1:0]                       cdb_value;
  logic                                   all_empty;
  logic                                   err_tag0;
  logic [31:0]                            bcast_count;

  // FU / pipeline control side
  modport master (
    output flush, fu_valid, fu_rob_tag, fu_value,
    input  fu_stall, cdb_valid, cdb_rob_tag, cdb_value,
           all_empty, err_tag0, bcast_count
  );

  // Broadcaster side
  modport slave (
    input  flush, fu_valid, fu_rob_tag, fu_value,
    output fu_stall, cdb_valid, cdb_rob_tag, cdb_value,
           all_empty, err_tag0, bcast_count
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one result FIFO per FU, round-robin grant over the FIFO
// heads, one registered broadcast per cycle.

// Per-FU result FIFO. Head is read combinationally; no push->pop bypass.
module cdb_fu_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int VAL_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [VAL_W-1:0] i_val,
  input  logic             i_pop,
  output logic [TAG_W-1:0] o_tag,
  output logic [VAL_W-1:0] o_val,
  output logic [CNT_W-1:0] o_count
);
  logic [TAG_W-1:0] r_mem_tag [DEPTH];
  logic [VAL_W-1:0] r_mem_val [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem_tag[r_wr] <= i_tag;
      r_mem_val[r_wr] <= i_val;
    end
  end

  // Pointers wrap naturally; flush empties the queue like reset
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_tag   = r_mem_tag[r_rd];
  assign o_val   = r_mem_val[r_rd];
  assign o_count = r_cnt;
endmodule

module cdb_broadcaster #(
  parameter int NUM_FU      = 4,
  parameter int Q_DEPTH     = 4,
  parameter int VAL_W       = 32,
  parameter int ROB_TAG_LEN = 6
) (
  input logic              clk,
  input logic              reset,
  cdb_broadcaster_if.slave bus
);
  localparam int CNT_W = $clog2(Q_DEPTH) + 1;
  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [VAL_W-1:0]       value;
  } cdb_data_t;

  logic [NUM_FU-1:0]                  w_push;
  logic [NUM_FU-1:0]                  w_pop;
  logic [NUM_FU-1:0]                  w_stall;
  logic [NUM_FU-1:0]                  w_nonempty;
  logic [NUM_FU-1:0]                  w_tag_zero;
  logic [NUM_FU-1:0][CNT_W-1:0]       w_count;
  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] w_head_tag;
  logic [NUM_FU-1:0][VAL_W-1:0]       w_head_val;

  logic            w_gnt_vld;
  logic [RR_W-1:0] w_gnt_idx;
  logic [RR_W-1:0] w_rr_nxt;

  logic [RR_W-1:0] r_rr_ptr;
  cdb_data_t       r_cdb;
  logic            r_err_tag0;
  logic [31:0]     r_bcast_count;

  // Per-FU lanes: stall depends only on the registered count, so there is no
  // path from fu_valid or the grant back to fu_stall. Tag 0 is never queued.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    assign w_stall[g]    = (w_count[g] == CNT_W'(Q_DEPTH));
    assign w_nonempty[g] = (w_count[g] != '0);
    assign w_tag_zero[g] = bus.fu_valid[g] && (bus.fu_rob_tag[g] == '0);
    assign w_push[g]     = bus.fu_valid[g] && !w_stall[g] && !bus.flush &&
                           (bus.fu_rob_tag[g] != '0);

    cdb_fu_fifo #(
      .DEPTH (Q_DEPTH),
      .TAG_W (ROB_TAG_LEN),
      .VAL_W (VAL_W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (bus.flush),
      .i_push  (w_push[g]),
      .i_tag   (bus.fu_rob_tag[g]),
      .i_val   (bus.fu_value[g]),
      .i_pop   (w_pop[g]),
      .o_tag   (w_head_tag[g]),
      .o_val   (w_head_val[g]),
      .o_count (w_count[g])
    );
  end

  // Round-robin scan from r_rr_ptr; first non-empty FIFO wins
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_FU;
      if (!w_gnt_vld && w_nonempty[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = RR_W'(idx);
      end
    end
  end

  // Pop the granted head and advance the pointer past the winner
  always_comb begin
    w_pop = '0;
    if (w_gnt_vld) w_pop[w_gnt_idx] = 1'b1;
    w_rr_nxt = (int'(w_gnt_idx) == NUM_FU - 1) ? '0 : w_gnt_idx + 1'b1;
  end

  // Broadcast register, arbitration pointer and status counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_cdb         <= '0;
      r_err_tag0    <= 1'b0;
      r_bcast_count <= '0;
    end else if (bus.flush) begin
      // Everything queued is squashed; counters and sticky error survive
      r_rr_ptr <= '0;
      r_cdb    <= '0;
    end else begin
      r_err_tag0 <= r_err_tag0 | (|w_tag_zero);
      if (w_gnt_vld) begin
        r_cdb.valid   <= 1'b1;
        r_cdb.rob_tag <= w_head_tag[w_gnt_idx];
        r_cdb.value   <= w_head_val[w_gnt_idx];
        r_bcast_count <= r_bcast_count + 32'd1;
        r_rr_ptr      <= w_rr_nxt;
      end else begin
        r_cdb <= '0;
      end
    end
  end

  assign bus.fu_stall    = w_stall;
  assign bus.cdb_valid   = r_cdb.valid;
  assign bus.cdb_rob_tag = r_cdb.rob_tag;
  assign bus.cdb_value   = r_cdb.value;
  assign bus.all_empty   = !(|w_nonempty) && !r_cdb.valid;
  assign bus.err_tag0    = r_err_tag0;
  assign bus.bcast_count = r_bcast_count;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, latency, round-robin order,
// backpressure, flush and tag-0 handling.
module tb_cdb_broadcaster;
  localparam int NFU  = 4;
  localparam int TAGW = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  int unsigned log_tag[$];
  logic [31:0] log_val[$];

  always #5 clk = ~clk;

  cdb_broadcaster_if #(.NUM_FU(NFU), .ROB_TAG_LEN(TAGW), .VAL_W(32)) bus ();

  cdb_broadcaster #(
    .NUM_FU(NFU), .Q_DEPTH(4), .VAL_W(32), .ROB_TAG_LEN(TAGW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Record every broadcast, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && bus.cdb_valid) begin
      log_tag.push_back(int'(bus.cdb_rob_tag));
      log_val.push_back(bus.cdb_value);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.fu_valid   = '0;
    bus.fu_rob_tag = '0;
    bus.fu_value   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    log_tag.delete();
    log_val.delete();
  endtask

  initial begin
    int nxt[NFU];
    int base[NFU];
    logic [NFU-1:0] st;
    bit saw_stall;
    int cyc;
    int k;

    // ---- reset state
    do_reset();
    chk("rst_stall", bus.fu_stall, 0);
    chk("rst_empty", bus.all_empty, 1);
    chk("rst_cdbv", bus.cdb_valid, 0);
    chk("rst_bcast", bus.bcast_count, 0);
    chk("rst_err", bus.err_tag0, 0);

    // ---- 1: single result, 2-cycle latency
    bus.fu_valid[0]   = 1'b1;
    bus.fu_rob_tag[0] = 7'd5;
    bus.fu_value[0]   = 32'hDEAD;
    tick();
    idle_inputs();
    chk("t1_cdbv_n", bus.cdb_valid, 0);
    tick();
    chk("t1_cdbv", bus.cdb_valid, 1);
    chk("t1_tag", bus.cdb_rob_tag, 5);
    chk("t1_val", bus.cdb_value, 32'hDEAD);
    chk("t1_bcast", bus.bcast_count, 1);
    tick();
    chk("t1_cdbv_off", bus.cdb_valid, 0);
    chk("t1_empty", bus.all_empty, 1);

    // ---- 2: four simultaneous results broadcast 1,2,3,4
    do_reset();
    for (int i = 0; i < NFU; i++) begin
      bus.fu_valid[i]   = 1'b1;
      bus.fu_rob_tag[i] = TAGW'(i + 1);
      bus.fu_value[i]   = 32'h100 + 32'(i + 1);
    end
    tick();
    idle_inputs();
    repeat (6) tick();
    chk("t2_n", log_tag.size(), 4);
    for (int i = 0; i < 4 && i < log_tag.size(); i++) begin
      chk("t2_tag", log_tag[i], i + 1);
      chk("t2_val", log_val[i], 32'h100 + 32'(i + 1));
    end
    chk("t2_rr", dut.r_rr_ptr, 0);
    chk("t2_bcast", bus.bcast_count, 4);
    chk("t2_empty", bus.all_empty, 1);

    // ---- 3: FU0 and FU2 contend, grants alternate
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.fu_valid[0]   = 1'b1;
      bus.fu_rob_tag[0] = TAGW'(20 + c);
      bus.fu_valid[2]   = 1'b1;
      bus.fu_rob_tag[2] = TAGW'(30 + c);
      chk("t3_stall", bus.fu_stall, 0);
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      if (c < 4) chk("t3_stall_d", bus.fu_stall, 0);
      tick();
    end
    chk("t3_n", log_tag.size(), 8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++)
      chk("t3_ord", log_tag[i], (i % 2 == 0) ? 20 + i / 2 : 30 + i / 2);

    // ---- 4: all FUs streaming, FU1 backpressured but lossless and ordered
    do_reset();
    base = '{40, 10, 50, 60};
    nxt  = '{0, 0, 0, 0};
    saw_stall = 1'b0;
    cyc = 0;
    while ((nxt[0] < 10 || nxt[1] < 10 || nxt[2] < 10 || nxt[3] < 10) && cyc < 200) begin
      for (int i = 0; i < NFU; i++) begin
        bus.fu_valid[i]   = (nxt[i] < 10);
        bus.fu_rob_tag[i] = TAGW'(base[i] + nxt[i]);
        bus.fu_value[i]   = 32'(base[i] + nxt[i]);
      end
      st = bus.fu_stall;
      if (st[1]) saw_stall = 1'b1;
      tick();
      for (int i = 0; i < NFU; i++)
        if (bus.fu_valid[i] && !st[i]) nxt[i]++;
      cyc++;
    end
    idle_inputs();
    chk("t4_bound", (cyc < 200), 1);
    chk("t4_stall1", saw_stall, 1);
    repeat (50) tick();
    chk("t4_n", log_tag.size(), 40);
    k = 0;
    for (int j = 0; j < log_tag.size(); j++) begin
      if (log_tag[j] >= 10 && log_tag[j] <= 19) begin
        chk("t4_ord", log_tag[j], 10 + k);
        k++;
      end
    end
    chk("t4_fu1_n", k, 10);
    chk("t4_empty", bus.all_empty, 1);

    // ---- 5: flush drops queued results and the flush-cycle input
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      bus.fu_valid[0]   = 1'b1;
      bus.fu_rob_tag[0] = TAGW'(c);
      bus.fu_value[0]   = 32'(c);
      tick();
    end
    bus.fu_rob_tag[0] = 7'd7;
    bus.flush         = 1'b1;
    tick();
    idle_inputs();
    chk("t5_cdbv", bus.cdb_valid, 0);
    chk("t5_empty", bus.all_empty, 1);
    chk("t5_bcast", bus.bcast_count, 2);
    repeat (5) tick();
    chk("t5_n", log_tag.size(), 2);
    for (int j = 0; j < log_tag.size(); j++)
      chk("t5_tag", log_tag[j], j + 1);
    chk("t5_bcast_h", bus.bcast_count, 2);

    // ---- 6: tag 0 discarded, sticky error
    log_tag.delete();
    log_val.delete();
    bus.fu_valid[3]   = 1'b1;
    bus.fu_rob_tag[3] = '0;
    bus.fu_value[3]   = 32'd99;
    chk("t6_stall", bus.fu_stall[3], 0);
    tick();
    idle_inputs();
    chk("t6_err", bus.err_tag0, 1);
    repeat (4) tick();
    chk("t6_err_h", bus.err_tag0, 1);
    chk("t6_n", log_tag.size(), 0);
    chk("t6_bcast", bus.bcast_count, 2);
    chk("t6_empty", bus.all_empty, 1);
    do_reset();
    chk("t6_err_rst", bus.err_tag0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
